nibble_serial_subtractor: RTL and testbench

//  Multi-nibble subtractor: computes diff = x - y over NIBBLES 4-bit digits, one nibble per clock, LSB first.

---
 rtl/nibble_serial_subtractor_pkg.sv | 11 +
 rtl/nibble_serial_subtractor_slice.sv | 18 +
 rtl/nibble_serial_subtractor.sv | 160 ++++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: digit width and FSM encoding.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit subtract slice with borrow in/out: {b,d} = xn - yn - bin.
module nibble_serial_subtractor_slice
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE_W-1:0] xn,
    input  logic [NIBBLE_W-1:0] yn,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                b
);

    logic [NIBBLE_W:0] res_s;

    // Zero-extended subtraction; the top bit of the 5-bit result is the borrow.
    assign res_s  = {1'b0, xn} - {1'b0, yn} - {{NIBBLE_W{1'b0}}, bin};
    assign {b, d} = res_s;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-nibble subtractor: one 4-bit slice reused LSB-first across NIBBLES cycles,
// wrapped in a start/busy/done handshake with registered outputs.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   x,
    input  logic [NIBBLE_W*NIBBLES-1:0]   y,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   diff,
    output logic                          borrow_out
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES + 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       x_sh_r;
    logic [W-1:0]       y_sh_r;
    logic [W-1:0]       diff_r;
    logic [W-1:0]       diff_wr_s;
    logic               borrow_r;
    logic               borrow_out_r;
    logic               busy_r;
    logic               done_r;
    logic               last_s;
    logic               accept_s;
    logic               step_s;
    logic               finish_s;
    logic [NIBBLE_W-1:0] slice_d_s;
    logic               slice_b_s;

    // Operands are shifted right each step, so the active nibble is always the low one.
    nibble_serial_subtractor_slice u_slice (
        .xn  (x_sh_r[NIBBLE_W-1:0]),
        .yn  (y_sh_r[NIBBLE_W-1:0]),
        .bin (borrow_r),
        .d   (slice_d_s),
        .b   (slice_b_s)
    );

    assign last_s = (idx_r == IDX_W'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start only matters in IDLE; RUN lasts exactly NIBBLES cycles.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = start;
            end
            ST_RUN: begin
                step_s   = 1'b1;
                finish_s = last_s;
            end
            default: begin
                accept_s = 1'b0;
                step_s   = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Drop the slice result into the diff nibble selected by idx.
    always_comb begin
        diff_wr_s = diff_r;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                diff_wr_s[i*NIBBLE_W +: NIBBLE_W] = slice_d_s;
            end else begin
                diff_wr_s[i*NIBBLE_W +: NIBBLE_W] = diff_r[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Datapath: operand capture, per-nibble step, borrow chain and final borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh_r       <= '0;
            y_sh_r       <= '0;
            diff_r       <= '0;
            idx_r        <= '0;
            borrow_r     <= 1'b0;
            borrow_out_r <= 1'b0;
        end else if (accept_s) begin
            x_sh_r   <= x;
            y_sh_r   <= y;
            diff_r   <= '0;
            idx_r    <= '0;
            borrow_r <= 1'b0;
        end else if (step_s) begin
            x_sh_r   <= x_sh_r >> NIBBLE_W;
            y_sh_r   <= y_sh_r >> NIBBLE_W;
            diff_r   <= diff_wr_s;
            borrow_r <= slice_b_s;
            idx_r    <= idx_r + IDX_W'(1);
            if (finish_s) begin
                borrow_out_r <= slice_b_s;
            end
        end
    end

    // Registered handshake outputs: busy tracks the upcoming state, done follows the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= finish_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: NIBBLES=4 main instance plus a NIBBLES=1 instance.
module tb_nibble_serial_subtractor;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow_out;

    logic        start1;
    logic [3:0]  x1;
    logic [3:0]  y1;
    logic        busy1;
    logic        done1;
    logic [3:0]  diff1;
    logic        borrow1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    nibble_serial_subtractor #(.NIBBLES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    nibble_serial_subtractor #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        x = a; y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        x = 16'h0; y = 16'h0; x1 = 4'h0; y1 = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow_out} !== 19'h0) begin
            errors++;
            $display("FAIL reset_n4: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
        end
        checks++;
        if ({busy1, done1, diff1, borrow1} !== 7'h0) begin
            errors++;
            $display("FAIL reset_n1: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy1, done1, diff1, borrow1);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] tx [4] = '{16'h1234, 16'h0100, 16'h0003, 16'h0000};
        logic [15:0] ty [4] = '{16'h0123, 16'h0001, 16'h0006, 16'h0000};
        logic [15:0] td [4] = '{16'h1111, 16'h00FF, 16'hFFFD, 16'h0000};
        logic        tb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit   seen;
        int   cyc;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            pulse_start(tx[k], ty[k]);
            sb_q.push_back('{diff: td[k], borrow: tb[k]});
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got %b, want 1", k, busy);
            end
            wait_done(20, seen, cyc);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL basic_timeout[%0d]: no done within 20 cycles", k);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                if (diff !== e.diff || borrow_out !== e.borrow) begin
                    errors++;
                    $display("FAIL basic_result[%0d]: got diff=%h borrow=%b, want diff=%h borrow=%b",
                             k, diff, borrow_out, e.diff, e.borrow);
                end
                checks++;
                if (cyc !== 4) begin
                    errors++;
                    $display("FAIL basic_latency[%0d]: got %0d, want 4", k, cyc);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_done_pulse[%0d]: got done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   dones = 0;
        exp_t e;
        @(negedge clk);
        x = 16'h7000; y = 16'h6000; start = 1'b1;
        sb_q.push_back('{diff: 16'h1000, borrow: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 16'hFFFF; y = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (diff !== e.diff || borrow_out !== e.borrow) begin
                        errors++;
                        $display("FAIL ignore_result: got diff=%h borrow=%b, want diff=%h borrow=%b",
                                 diff, borrow_out, e.diff, e.borrow);
                    end
                end
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d, want 1", dones);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        int   dones = 0;
        bit   seen;
        int   cyc;
        exp_t e;
        pulse_start(16'h1234, 16'h0123);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || diff !== 16'h0 || done !== 1'b0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got busy=%b diff=%h done=%b borrow=%b, want 0 0000 0 0",
                     busy, diff, done, borrow_out);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: got %0d done pulses, want 0", dones);
        end
        pulse_start(16'h0005, 16'h0003);
        sb_q.push_back('{diff: 16'h0002, borrow: 1'b0});
        wait_done(20, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_restart: no done within 20 cycles");
            sb_q.delete();
        end else begin
            e = sb_q.pop_front();
            if (diff !== e.diff || borrow_out !== e.borrow) begin
                errors++;
                $display("FAIL rst_mid_restart: got diff=%h borrow=%b, want diff=%h borrow=%b",
                         diff, borrow_out, e.diff, e.borrow);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   dcount = 0;
        int   t [2] = '{0, 0};
        exp_t e;
        @(negedge clk);
        x = 16'h1234; y = 16'h0123; start = 1'b1;
        sb_q.push_back('{diff: 16'h1111, borrow: 1'b0});
        sb_q.push_back('{diff: 16'hFFFF, borrow: 1'b1});
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                t[dcount] = i;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (diff !== e.diff || borrow_out !== e.borrow) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got diff=%h borrow=%b, want diff=%h borrow=%b",
                                 dcount, diff, borrow_out, e.diff, e.borrow);
                    end
                end
                dcount++;
                if (dcount == 1) begin
                    x = 16'h0000; y = 16'h0001;
                end
                if (dcount == 2) break;
            end else if (dcount == 1 && start) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (dcount !== 2 || (t[1] - t[0]) !== 5) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d dones at %0d/%0d, want 2 dones 5 apart", dcount, t[0], t[1]);
        end
        sb_q.delete();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        bit   seen;
        int   cyc;
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (k == 0) b = a;
            pulse_start(a, b);
            sb_q.push_back('{diff: a - b, borrow: (a < b)});
            wait_done(20, seen, cyc);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL rand_timeout[%0d]: no done within 20 cycles", k);
                sb_q.delete();
            end else begin
                e = sb_q.pop_front();
                if (diff !== e.diff || borrow_out !== e.borrow) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: %h-%h got diff=%h borrow=%b, want diff=%h borrow=%b",
                             k, a, b, diff, borrow_out, e.diff, e.borrow);
                end
            end
        end
    endtask

    task automatic test_nibbles1();
        logic [3:0] ta [2] = '{4'hD, 4'h3};
        logic [3:0] tb [2] = '{4'h5, 4'h5};
        logic [3:0] td [2] = '{4'h8, 4'hE};
        logic       tw [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            x1 = ta[k]; y1 = tb[k]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL n1_busy[%0d]: got busy=%b done=%b, want 1 0", k, busy1, done1);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== td[k] || borrow1 !== tw[k]) begin
                errors++;
                $display("FAIL n1_result[%0d]: got done=%b busy=%b diff=%h borrow=%b, want 1 0 %h %b",
                         k, done1, busy1, diff1, borrow1, td[k], tw[k]);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b0) begin
                errors++;
                $display("FAIL n1_done_pulse[%0d]: got %b, want 0", k, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_nibbles1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
